// File: rtl/cube_pkg.sv
// Shared encodings for the cube move engine and its move scheduler.
//
// Contents:
//   - face indices and the two external rotation encodings (manual, random)
//   - quarter-turn-count encoding used on the engine interface
//   - sched_state_t, the scheduler state enum
//   - man_rot_qt / rand_rot_qt: map the request encodings to clockwise quarter turns
//   - inv_rot: quarter-turn count of the inverse move
//   - SOLVED_CUBE: 54 stickers x 3 bits, every sticker carrying its face index
package cube_pkg;

  localparam int unsigned NUM_FACES = 6;

  localparam logic [2:0] FACE_U   = 3'd0;
  localparam logic [2:0] FACE_R   = 3'd1;
  localparam logic [2:0] FACE_F   = 3'd2;
  localparam logic [2:0] FACE_D   = 3'd3;
  localparam logic [2:0] FACE_L   = 3'd4;
  localparam logic [2:0] FACE_B   = 3'd5;
  localparam logic [2:0] FACE_MAX = FACE_B;

  // Manual rotation encoding
  localparam logic [1:0] MAN_ROT_NONE = 2'b00;
  localparam logic [1:0] MAN_ROT_CW   = 2'b01;
  localparam logic [1:0] MAN_ROT_CCW  = 2'b10;
  localparam logic [1:0] MAN_ROT_DBL  = 2'b11;

  // Random-generator rotation encoding (3 folds onto CW)
  localparam logic [1:0] RAND_ROT_CW  = 2'd0;
  localparam logic [1:0] RAND_ROT_CCW = 2'd1;
  localparam logic [1:0] RAND_ROT_DBL = 2'd2;

  // Clockwise quarter-turn counts presented to the engine
  localparam logic [2:0] QT_NONE = 3'd0;
  localparam logic [2:0] QT_CW   = 3'd1;
  localparam logic [2:0] QT_DBL  = 3'd2;
  localparam logic [2:0] QT_CCW  = 3'd3;

  localparam int unsigned CUBE_W = 162;
  localparam logic [CUBE_W-1:0] SOLVED_CUBE = {{9{FACE_B}}, {9{FACE_L}}, {9{FACE_D}},
                                               {9{FACE_F}}, {9{FACE_R}}, {9{FACE_U}}};

  typedef enum logic [2:0] {
    StIdle,
    StMan,
    StScr,
    StUndo,
    StDone
  } sched_state_t;

  function automatic logic [2:0] man_rot_qt(input logic [1:0] rot);
    logic [2:0] qt;
    case (rot)
      MAN_ROT_CW:  qt = QT_CW;
      MAN_ROT_CCW: qt = QT_CCW;
      MAN_ROT_DBL: qt = QT_DBL;
      default:     qt = QT_NONE;
    endcase
    return qt;
  endfunction

  function automatic logic [2:0] rand_rot_qt(input logic [1:0] rot);
    logic [2:0] qt;
    case (rot)
      RAND_ROT_CCW: qt = QT_CCW;
      RAND_ROT_DBL: qt = QT_DBL;
      default:      qt = QT_CW;
    endcase
    return qt;
  endfunction

  // Undoing n clockwise quarter turns is 4-n clockwise quarter turns.
  function automatic logic [2:0] inv_rot(input logic [2:0] qt);
    return 3'd4 - qt;
  endfunction

endpackage

// File: rtl/move_history.sv
// Move-history LIFO kept as a ring buffer. A push onto a full buffer overwrites the
// oldest entry, so the most recent DEPTH moves are always recoverable.
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset (level only; storage is not reset)
//   push       write din on top
//   pop        discard top entry (ignored when empty)
//   clr        empty the history
//   din        entry to push
//   top        most recently pushed valid entry (don't-care when level is 0)
//   level      number of valid entries, 0..DEPTH
module move_history #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned W     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      clr,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              top,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr_q;    // next slot to write
  logic [AW-1:0] ptr_m1;
  logic [AW:0]   level_q;

  assign ptr_m1 = ptr_q - PTR_ONE;
  assign top    = mem[ptr_m1];
  assign level  = level_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      level_q <= '0;
    end else if (clr) begin
      level_q <= '0;
    end else if (push) begin
      // When full the write slot holds the oldest entry, so advancing over it drops it.
      ptr_q <= ptr_q + PTR_ONE;
      if (level_q != LVL_FULL) begin
        level_q <= level_q + LVL_ONE;
      end
    end else if (pop && (level_q != '0)) begin
      ptr_q   <= ptr_m1;
      level_q <= level_q - LVL_ONE;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Move scheduler: arbitrates manual, scramble and undo requests and issues one move
// at a time to the turn engine over a valid/ready handshake. Undo replays the
// inverse of the last recorded move from a 5-bit-per-entry history LIFO.
//
// Build option: define SCHED_UNDO_EN to include the history LIFO and undo support.
// Without it undo_req is ignored and hist_level is tied to 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   man_valid/face/rot  manual move request (level, held until man_ready)
//   man_ready           manual request accepted this cycle when both high
//   scr_start           single-cycle scramble request
//   undo_req            single-cycle undo request
//   rand_face/rot       random move source for scrambles
//   mv_valid/face/rot   registered move to the engine (rot = CW quarter turns)
//   mv_ready            engine latches on mv_valid & mv_ready
//   solved              cube register holds the solved pattern
//   busy, done          not idle / in the solved-done state
//   move_count          net manual moves, saturating at CNT_MAX
//   hist_level          valid history entries
module move_scheduler
  import cube_pkg::*;
#(
  parameter int unsigned HIST_DEPTH   = 64,
  parameter int unsigned SCRAMBLE_LEN = 20,
  parameter int unsigned CNT_MAX      = 999
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         man_valid,
  input  logic [2:0]                   man_face,
  input  logic [1:0]                   man_rot,
  output logic                         man_ready,
  input  logic                         scr_start,
  input  logic                         undo_req,
  input  logic [2:0]                   rand_face,
  input  logic [1:0]                   rand_rot,
  output logic                         mv_valid,
  output logic [2:0]                   mv_face,
  output logic [2:0]                   mv_rot,
  input  logic                         mv_ready,
  input  logic                         solved,
  output logic                         busy,
  output logic                         done,
  output logic [9:0]                   move_count,
  output logic [$clog2(HIST_DEPTH):0]  hist_level
);

  localparam int unsigned LVL_W    = $clog2(HIST_DEPTH) + 1;
  localparam logic [9:0]  CNT_SAT  = CNT_MAX[9:0];
  localparam logic [7:0]  SCR_LAST = 8'(SCRAMBLE_LEN - 1);

  sched_state_t state_q;
  logic         mv_valid_q;
  logic [2:0]   mv_face_q;
  logic [2:0]   mv_rot_q;
  logic         busy_q;
  logic         done_q;
  logic         armed_q;
  logic [9:0]   move_count_q;
  logic [7:0]   scr_cnt_q;

  logic             handshake;
  logic             scr_go;
  logic             scr_last;
  logic             undo_go;
  logic [LVL_W-1:0] hist_lvl;

  assign handshake = mv_valid_q & mv_ready;
  // Scramble is the only request honoured in DONE.
  assign scr_go    = scr_start & ((state_q == StIdle) | (state_q == StDone));
  assign scr_last  = (scr_cnt_q == SCR_LAST);

`ifdef SCHED_UNDO_EN
  logic       hist_push;
  logic       hist_pop;
  logic       hist_clr;
  logic [4:0] hist_top;

  assign undo_go   = undo_req;
  assign hist_push = (state_q == StMan) & handshake;
  assign hist_pop  = (state_q == StUndo) & handshake;
  assign hist_clr  = (state_q == StScr) & handshake & scr_last;

  move_history #(
    .DEPTH (HIST_DEPTH),
    .W     (5)
  ) u_move_history (
    .clk   (clk),
    .rst   (rst),
    .push  (hist_push),
    .pop   (hist_pop),
    .clr   (hist_clr),
    .din   ({mv_face_q, mv_rot_q[1:0]}),
    .top   (hist_top),
    .level (hist_lvl)
  );
`else
  logic unused_undo_req;

  assign unused_undo_req = undo_req;
  assign undo_go         = 1'b0;
  assign hist_lvl        = '0;
`endif

  // A pending manual request loses to any pulse in the same cycle.
  assign man_ready  = (state_q == StIdle) & ~scr_start & ~undo_go;

  assign mv_valid   = mv_valid_q;
  assign mv_face    = mv_face_q;
  assign mv_rot     = mv_rot_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign move_count = move_count_q;
  assign hist_level = hist_lvl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      mv_valid_q   <= 1'b0;
      mv_face_q    <= '0;
      mv_rot_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      armed_q      <= 1'b0;
      move_count_q <= '0;
      scr_cnt_q    <= '0;
    end else if (scr_go) begin
      state_q    <= StScr;
      mv_valid_q <= 1'b1;
      mv_face_q  <= rand_face;
      mv_rot_q   <= rand_rot_qt(rand_rot);
      scr_cnt_q  <= '0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (undo_go) begin
`ifdef SCHED_UNDO_EN
            if (hist_lvl != '0) begin
              state_q    <= StUndo;
              mv_valid_q <= 1'b1;
              mv_face_q  <= hist_top[4:2];
              mv_rot_q   <= inv_rot({1'b0, hist_top[1:0]});
              busy_q     <= 1'b1;
            end
`endif
          end else if (man_valid) begin
            // Null rotations and bad faces are consumed without issuing anything.
            if ((man_rot != MAN_ROT_NONE) && (man_face <= FACE_MAX)) begin
              state_q    <= StMan;
              mv_valid_q <= 1'b1;
              mv_face_q  <= man_face;
              mv_rot_q   <= man_rot_qt(man_rot);
              busy_q     <= 1'b1;
            end
          end else if (solved && armed_q) begin
            state_q <= StDone;
            busy_q  <= 1'b1;
            done_q  <= 1'b1;
          end
        end

        StMan: begin
          if (handshake) begin
            state_q    <= StIdle;
            mv_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            armed_q    <= 1'b1;
            if (move_count_q < CNT_SAT) begin
              move_count_q <= move_count_q + 10'd1;
            end
          end
        end

        StUndo: begin
          if (handshake) begin
            state_q    <= StIdle;
            mv_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            if (move_count_q != '0) begin
              move_count_q <= move_count_q - 10'd1;
            end
          end
        end

        StScr: begin
          if (handshake) begin
            if (scr_last) begin
              state_q      <= StIdle;
              mv_valid_q   <= 1'b0;
              busy_q       <= 1'b0;
              armed_q      <= 1'b1;
              move_count_q <= '0;
            end else begin
              scr_cnt_q <= scr_cnt_q + 8'd1;
              mv_face_q <= rand_face;
              mv_rot_q  <= rand_rot_qt(rand_rot);
            end
          end
        end

        StDone: begin
          // Only a scramble leaves DONE; handled above.
        end

        default: begin
          state_q    <= StIdle;
          mv_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios plus a randomized
// phase, all compared against a transaction-level model (history queue, counter,
// armed flag). Works with and without SCHED_UNDO_EN.
module tb_move_scheduler;

  localparam int HistDepth = 64;
  localparam int ScrLen    = 20;
  localparam int CntMax    = 60;
`ifdef SCHED_UNDO_EN
  localparam bit UndoEn = 1'b1;
`else
  localparam bit UndoEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       man_valid, man_ready, scr_start, undo_req, mv_valid, mv_ready;
  logic       solved, busy, done;
  logic [2:0] man_face, rand_face, mv_face, mv_rot;
  logic [1:0] man_rot, rand_rot;
  logic [9:0] move_count;
  logic [6:0] hist_level;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  int m_count;
  bit m_armed;
  int hist_q[$];          // entries face*4 + quarter turns, newest at the back
  int man_qt[4]  = '{0, 1, 3, 2};
  int rand_qt[4] = '{1, 3, 2, 1};

  move_scheduler #(
    .HIST_DEPTH   (HistDepth),
    .SCRAMBLE_LEN (ScrLen),
    .CNT_MAX      (CntMax)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .man_valid  (man_valid),
    .man_face   (man_face),
    .man_rot    (man_rot),
    .man_ready  (man_ready),
    .scr_start  (scr_start),
    .undo_req   (undo_req),
    .rand_face  (rand_face),
    .rand_rot   (rand_rot),
    .mv_valid   (mv_valid),
    .mv_face    (mv_face),
    .mv_rot     (mv_rot),
    .mv_ready   (mv_ready),
    .solved     (solved),
    .busy       (busy),
    .done       (done),
    .move_count (move_count),
    .hist_level (hist_level)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_level();
    return UndoEn ? hist_q.size() : 0;
  endfunction

  task automatic apply_reset();
    rst       = 1'b0;
    man_valid = 1'b0;
    scr_start = 1'b0;
    undo_req  = 1'b0;
    solved    = 1'b0;
    mv_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    m_count = 0;
    m_armed = 1'b0;
    hist_q.delete();
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_manual(input int face, input int rot, input int stall);
    int qt;
    man_valid = 1'b1;
    man_face  = 3'(face);
    man_rot   = 2'(rot);
    #1 check("man_ready_idle", man_ready, 1);
    @(negedge clk);
    man_valid = 1'b0;
    if (rot == 0 || face > 5) begin
      check("null_man_valid", mv_valid, 0);
      check("null_man_busy", busy, 0);
      return;
    end
    qt = man_qt[rot];
    check("man_mv_valid", mv_valid, 1);
    check("man_mv_face", mv_face, face);
    check("man_mv_rot", mv_rot, qt);
    check("man_busy", busy, 1);
    mv_ready = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      check("man_hold_valid", mv_valid, 1);
      check("man_hold_face", mv_face, face);
      check("man_hold_rot", mv_rot, qt);
    end
    mv_ready = 1'b1;
    @(negedge clk);
    hist_q.push_back(face * 4 + qt);
    if (hist_q.size() > HistDepth) void'(hist_q.pop_front());
    if (m_count < CntMax) m_count++;
    m_armed = 1'b1;
    check("man_after_valid", mv_valid, 0);
    check("man_count", move_count, m_count);
    check("man_level", hist_level, exp_level());
  endtask

  task automatic do_undo(input int stall);
    int e, face, qt;
    undo_req = 1'b1;
    #1 check("undo_man_ready", man_ready, UndoEn ? 0 : 1);
    @(negedge clk);
    undo_req = 1'b0;
    if (!UndoEn || hist_q.size() == 0) begin
      check("undo_none_valid", mv_valid, 0);
      check("undo_none_busy", busy, 0);
      check("undo_none_count", move_count, m_count);
      return;
    end
    e    = hist_q[$];
    face = e / 4;
    qt   = 4 - (e % 4);
    check("undo_mv_valid", mv_valid, 1);
    check("undo_mv_face", mv_face, face);
    check("undo_mv_rot", mv_rot, qt);
    mv_ready = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      check("undo_hold_face", mv_face, face);
      check("undo_hold_rot", mv_rot, qt);
    end
    mv_ready = 1'b1;
    @(negedge clk);
    void'(hist_q.pop_back());
    if (m_count > 0) m_count--;
    check("undo_after_valid", mv_valid, 0);
    check("undo_count", move_count, m_count);
    check("undo_level", hist_level, exp_level());
  endtask

  // with_others: raise undo_req and a held man_valid alongside scr_start, and re-pulse
  // scr_start/undo_req mid-scramble; man_valid is left asserted on return.
  task automatic do_scramble(input bit force3, input bit with_others, input int stall_pct,
                             input int mf, input int mr);
    int rf, rr, cnt, exp_f, exp_q, guard;
    rf = $urandom_range(0, 7);
    rr = force3 ? 3 : $urandom_range(0, 3);
    rand_face = 3'(rf);
    rand_rot  = 2'(rr);
    scr_start = 1'b1;
    if (with_others) begin
      undo_req  = 1'b1;
      man_valid = 1'b1;
      man_face  = 3'(mf);
      man_rot   = 2'(mr);
    end
    #1 check("scr_start_man_ready", man_ready, 0);
    @(negedge clk);
    scr_start = 1'b0;
    undo_req  = 1'b0;
    exp_f = rf;
    exp_q = rand_qt[rr];
    cnt   = 0;
    guard = 0;
    while (cnt < ScrLen && guard < 1000) begin
      guard++;
      check("scr_mv_valid", mv_valid, 1);
      check("scr_mv_face", mv_face, exp_f);
      check("scr_mv_rot", mv_rot, exp_q);
      check("scr_man_ready", man_ready, 0);
      scr_start = with_others && guard == 3;
      undo_req  = with_others && guard == 3;
      mv_ready  = ($urandom_range(0, 99) >= stall_pct);
      rf = $urandom_range(0, 7);
      rr = force3 ? 3 : $urandom_range(0, 3);
      rand_face = 3'(rf);
      rand_rot  = 2'(rr);
      if (mv_ready) begin
        cnt++;
        exp_f = rf;
        exp_q = rand_qt[rr];
      end
      @(negedge clk);
    end
    scr_start = 1'b0;
    undo_req  = 1'b0;
    mv_ready  = 1'b1;
    check("scr_handshakes", cnt, ScrLen);
    hist_q.delete();
    m_count = 0;
    m_armed = 1'b1;
    check("scr_end_valid", mv_valid, 0);
    check("scr_end_busy", busy, 0);
    check("scr_end_count", move_count, m_count);
    check("scr_end_level", hist_level, exp_level());
  endtask

  initial begin
    rand_face = '0;
    rand_rot  = '0;
    man_face  = '0;
    man_rot   = '0;
    apply_reset();
    check("rst_mv_valid", mv_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mv_face", mv_face, 0);
    check("rst_mv_rot", mv_rot, 0);
    check("rst_count", move_count, 0);
    check("rst_level", hist_level, 0);
    check("rst_man_ready", man_ready, 1);

    // Not armed yet: solved alone must not reach DONE.
    solved = 1'b1;
    @(negedge clk);
    check("unarmed_done", done, 0);
    solved = 1'b0;

    do_manual(2, 1, 0);

    apply_reset();
    do_manual(1, 1, 0);
    do_manual(4, 3, 0);
    do_undo(0);
    do_undo(0);
    do_undo(0);

    for (int i = 0; i < 150; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 6) do_manual($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op < 9) do_undo($urandom_range(0, 2));
      else do_scramble(1'b0, 1'b0, 25, 0, 0);
    end

    do_manual(3, 2, 5);

    // Full history and saturation of the counter
    apply_reset();
    for (int i = 0; i < 65; i++) do_manual($urandom_range(0, 5), $urandom_range(1, 3), 0);
    for (int i = 0; i < 65; i++) do_undo(0);

    // Simultaneous requests: scramble wins, undo dropped, manual waits
    do_manual(0, 1, 0);
    do_scramble(1'b1, 1'b1, 0, 5, 2);
    do_manual(5, 2, 0);

    // DONE entry and exit
    solved = 1'b1;
    @(negedge clk);
    check("done_set", done, m_armed ? 1 : 0);
    check("done_busy", busy, 1);
    man_valid = 1'b1;
    man_face  = 3'd0;
    man_rot   = 2'd1;
    #1 check("done_man_ready", man_ready, 0);
    @(negedge clk);
    check("done_man_ignored", mv_valid, 0);
    undo_req = 1'b1;
    @(negedge clk);
    undo_req = 1'b0;
    check("done_undo_ignored", mv_valid, 0);
    check("done_hold", done, 1);
    check("done_count", move_count, m_count);
    man_valid = 1'b0;
    solved    = 1'b0;
    @(negedge clk);
    check("done_sticky", done, 1);
    do_scramble(1'b0, 1'b0, 0, 0, 0);
    check("done_left", done, 0);

    // Reset in the middle of a scramble
    do_manual(1, 1, 0);
    do_manual(2, 3, 0);
    scr_start = 1'b1;
    @(negedge clk);
    scr_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_mv_valid", mv_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_count", move_count, 0);
    check("midrst_level", hist_level, 0);
    check("midrst_mv_face", mv_face, 0);
    check("midrst_mv_rot", mv_rot, 0);
    @(negedge clk);
    rst     = 1'b1;
    m_count = 0;
    m_armed = 1'b0;
    hist_q.delete();
    @(negedge clk);
    check("postrst_man_ready", man_ready, 1);
    check("postrst_mv_valid", mv_valid, 0);
    do_manual(4, 2, 1);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Sequencing controller for the cube move engine. It arbitrates between the manual-move, scramble and undo requesters, and issues one move at a time to the combinational turn engine through a valid/ready handshake. Undo is implemented as replay of the inverse move from a compact move-history LIFO (5 bits per entry), so no 162-bit state snapshots are stored. It also owns the move counter and the solved/done sequencing.

## Interface
- HIST_DEPTH, 64: history LIFO entries; power of two.
- SCRAMBLE_LEN, 20: moves issued per scramble; 1..255.
- CNT_MAX, 999: move_count saturation value.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- man_valid  in  1  manual move request; level, held until accepted
- man_face  in  3  face 0..5
- man_rot  in  2  00 none, 01 CW, 10 CCW, 11 double
- man_ready  out  1  manual request accepted when man_valid & man_ready
- scr_start  in  1  single-cycle scramble request
- undo_req  in  1  single-cycle undo request
- rand_face  in  3  random face from the move generator
- rand_rot  in  2  random rotation: 0 CW, 1 CCW, 2 double, 3 treated as CW
- mv_valid  out  1  move presented to engine
- mv_face  out  3  face to turn
- mv_rot  out  3  clockwise quarter-turn count 1..3
- mv_ready  in  1  engine/cube register latches on mv_valid & mv_ready
- solved  in  1  cube register equals the solved pattern
- busy  out  1  state != IDLE
- done  out  1  high in DONE
- move_count  out  10  net manual moves
- hist_level  out  $clog2(HIST_DEPTH)+1  valid history entries

## Operation
- States: IDLE, MAN, SCR, UNDO, DONE.
- **IDLE arbitration priority:** scr_start > undo_req > man_valid.
  - A losing pulse is dropped.
  - A losing man_valid stays pending; man_ready is 0 that cycle.
- **man_ready** is 1 only in IDLE with no scr_start/undo_req this cycle.
- **Manual accept:**
  - If man_rot=00 or man_face>5: consumed; no issue, no count, stay in IDLE.
  - Otherwise load mv_face/mv_rot (01→1, 10→3, 11→2) and go to MAN.
- **MAN:**
  - mv_valid=1 until handshake.
  - On handshake: push {face,rot}; move_count+1, saturating at CNT_MAX; set armed; go to IDLE.
  - When the LIFO is full, the push overwrites the oldest entry (ring), and hist_level stays at HIST_DEPTH.
- **undo_req in IDLE:**
  - hist_level=0: ignored.
  - Otherwise load the top entry with rot'=4-rot and go to UNDO.
- **UNDO:** on handshake, pop (hist_level-1), move_count-1 if >0, go to IDLE.
- **scr_start in IDLE or DONE:**
  - Load mv_* from rand_face/rand_rot, clear scr_cnt, go to SCR.
  - On each handshake: scr_cnt+1; reload mv_* from rand inputs.
  - On the SCRAMBLE_LEN-th handshake: hist_level←0, move_count←0, set armed, go to IDLE.
  - man_valid, undo_req and scr_start are ignored in SCR.
- **DONE entry:** IDLE → DONE when solved & armed & no request this cycle.
- **DONE:** done=1; manual and undo are ignored; only scr_start leaves (armed cleared on entry to SCR).
- **Reset values:** state IDLE; mv_valid, busy, done 0; mv_face, mv_rot 0; move_count 0; hist_level 0; armed 0; man_ready 1 once rst is released. LIFO contents are don't-care.
- **Reset mid-operation:** the in-flight move is abandoned immediately; the engine does not latch because mv_valid drops asynchronously.

## Timing
- mv_* are registered and stable while mv_valid & !mv_ready.
- Request accepted at edge N → mv_valid high from N to N+1.
- With mv_ready=1, a manual or undo move takes 2 cycles; the next request can be accepted at N+2.
- Scramble with mv_ready=1: exactly SCRAMBLE_LEN consecutive mv_valid cycles; rand inputs are sampled at entry and at each handshake edge.
- solved is evaluated only in IDLE, one cycle after the cube latches.
- move_count and hist_level update on the handshake edge.

## Configuration
- SCHED_UNDO_EN defined: history LIFO and UNDO state are present.
- SCHED_UNDO_EN undefined:
  - No LIFO storage; hist_level tied to 0.
  - undo_req is ignored.
  - MAN still counts moves.

## Structure
- Shared package cube_pkg holds:
  - face and rotation encoding constants
  - sched_state_t enum
  - function mapping man_rot/rand_rot to quarter-turn count
  - inverse-rotation function
  - SOLVED_CUBE constant
- Sub-module move_history: ring-buffer LIFO with push/pop, overwrite-oldest on full, level output. Instantiated only under SCHED_UNDO_EN.

## Test plan
- Manual: man_face=2, man_rot=01, mv_ready=1 → one mv_valid cycle with face 2 / rot 1; move_count=1, hist_level=1.
- Undo: after moves (1,CW) and (4,double), two undo_req pulses → issues (4,2) then (1,3); move_count=0, hist_level=0; a third undo_req → no mv_valid.
- Scramble: SCRAMBLE_LEN=20, mv_ready=1, rand_rot=3 → 20 consecutive mv_valid cycles with rot=1; then IDLE with move_count=0; man_valid during the scramble is never readied.
- Simultaneous: scr_start, undo_req and man_valid in the same IDLE cycle → SCR entered; undo dropped; manual issued after the scramble.
- Back-pressure and full LIFO: mv_ready low for 5 cycles → mv_* held; 65 moves with HIST_DEPTH=64 → hist_level=64, and 64 undos restore moves 65..2 in reverse.
- Done and reset: after a scramble, solved asserted in IDLE → done=1; man_valid ignored; rst pulsed low mid-SCR → all outputs at reset values the same cycle.
